light_sequencer: RTL and testbench



---
 rtl/light_pkg.sv | 23 ++
 rtl/dwell_timer.sv | 31 +++
 rtl/light_sequencer.sv | 126 ++++++++++++
 tb/tb_light_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared definitions for the lights sequencer: FSM encoding, colour code
// range, white level and the colour-advance rule.
package light_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    HOLD   = 2'd2
  } light_state_e;

  localparam logic [2:0]  COLOUR_FIRST = 3'd1;
  localparam logic [2:0]  COLOUR_LAST  = 3'd6;
  localparam logic [23:0] WHITE        = 24'hFFFFFF;

  // Step 1..5 forward, wrap 6 back to 1; the unused codes 0 and 7 recover to 1.
  function automatic logic [2:0] next_colour(input logic [2:0] colour);
    if (colour >= COLOUR_FIRST && colour < COLOUR_LAST) begin
      return colour + 3'd1;
    end
    return COLOUR_FIRST;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter with enable; stops at zero and flags it.
// Used by the sequencer both for the converter lookup wait and the dwell.
module dwell_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority over counting; counting saturates at zero.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values, independent of block evaluation order.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/light_sequencer.sv
// Autonomous colour sequencer for the lights datapath. Walks colour codes
// 1..6, waits out the converter lookup latency before committing the RGB,
// holds each colour for DWELL cycles, and applies a one-cycle-latency white
// override on the registered light output.
// Optional feature: define LIGHT_SEQ_STEP_EN to add the 'step' input, which
// forces an immediate colour advance when sampled high in HOLD.
module light_sequencer
  import light_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int ROM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef LIGHT_SEQ_STEP_EN
  input  logic        step,
`endif
  input  logic        run,
  input  logic        white_req,
  input  logic [23:0] rgb_in,
  output logic [2:0]  colour,
  output logic [23:0] light,
  output logic        light_valid,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_LOOKUP = LOOKUP;
  localparam logic [1:0] S_HOLD   = HOLD;

  localparam int LK_W = $clog2(ROM_LAT + 2);
  localparam int DW_W = $clog2(DWELL + 1);
  localparam logic [LK_W-1:0] LK_LOAD = LK_W'(ROM_LAT);
  localparam logic [DW_W-1:0] DW_LOAD = DW_W'(DWELL - 1);

  logic [1:0]  state, state_d;
  logic [2:0]  colour_d;
  logic [23:0] rgb_q, rgb_d;
  logic        valid_d;
  logic        lookup_load, dwell_load;
  logic        lookup_zero, dwell_zero;
  logic        step_fire;

`ifdef LIGHT_SEQ_STEP_EN
  assign step_fire = step;
`else
  assign step_fire = 1'b0;
`endif

  // Next-state, next-colour and RGB-capture decisions.
  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d     = state;
    colour_d    = colour;
    rgb_d       = rgb_q;
    valid_d     = light_valid;
    lookup_load = 1'b0;
    dwell_load  = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_d     = S_LOOKUP;
          colour_d    = COLOUR_FIRST;
          lookup_load = 1'b1;
        end
      end
      S_LOOKUP: begin
        if (lookup_zero) begin
          state_d    = S_HOLD;
          rgb_d      = rgb_in;
          valid_d    = 1'b1;
          dwell_load = 1'b1;
        end
      end
      S_HOLD: begin
        if ((dwell_zero && run) || step_fire) begin
          state_d     = S_LOOKUP;
          colour_d    = next_colour(colour);
          lookup_load = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  dwell_timer #(.WIDTH(LK_W)) u_lookup_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (lookup_load),
    .en       (state == S_LOOKUP),
    .load_val (LK_LOAD),
    .zero     (lookup_zero)
  );

  dwell_timer #(.WIDTH(DW_W)) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (dwell_load),
    .en       ((state == S_HOLD) && run),
    .load_val (DW_LOAD),
    .zero     (dwell_zero)
  );

  // Register FSM state, colour, committed RGB and the white-muxed output.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears the committed RGB too, so the
    // output can never show a value from before reset.
    if (rst) begin
      state       <= S_IDLE;
      colour      <= 3'd0;
      rgb_q       <= 24'd0;
      light       <= 24'd0;
      light_valid <= 1'b0;
    end else begin
      state       <= state_d;
      colour      <= colour_d;
      rgb_q       <= rgb_d;
      light_valid <= valid_d;
      light       <= white_req ? WHITE : rgb_d;
    end
  end

  assign busy = (state == S_LOOKUP);

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with a two-cycle converter model.
module tb_light_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic        run;
  logic        white_req;
  logic [23:0] rgb_in;
  logic [2:0]  colour;
  logic [23:0] light;
  logic        light_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  light_sequencer #(.DWELL(4), .ROM_LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef LIGHT_SEQ_STEP_EN
    .step        (step),
`endif
    .run         (run),
    .white_req   (white_req),
    .rgb_in      (rgb_in),
    .colour      (colour),
    .light       (light),
    .light_valid (light_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model_rgb(input logic [2:0] c);
    case (c)
      3'd1:    return 24'hFF0000;
      3'd2:    return 24'hFF7F00;
      3'd3:    return 24'hFFFF00;
      3'd4:    return 24'h00FF00;
      3'd5:    return 24'h0000FF;
      3'd6:    return 24'h8B00FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Converter model: rgb_in is valid two cycles after colour changes.
  logic [23:0] rom_p1 = 24'd0;
  logic [23:0] rom_p2 = 24'd0;
  always @(posedge clk) begin
    rom_p1 <= model_rgb(colour);
    rom_p2 <= rom_p1;
  end
  assign rgb_in = rom_p2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [23:0] prev_rgb;
    logic [23:0] exp_light;
    logic [2:0]  exp_c;

    rst = 1'b1; run = 1'b0; white_req = 1'b0; step = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset and idle with run low.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_colour", 32'(colour), 32'd0);
      check("idle_light", 32'(light), 32'd0);
      check("idle_valid", 32'(light_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Full sequence 1..6, seven cycles per colour.
    run = 1'b1;
    for (int c = 0; c < 6; c++) begin
      exp_c    = 3'(c + 1);
      prev_rgb = (c == 0) ? 24'd0 : model_rgb(3'(c));
      for (int i = 0; i < 7; i++) begin
        tick();
        check("seq_colour", 32'(colour), 32'(exp_c));
        check("seq_busy", 32'(busy), (i < 3) ? 32'd1 : 32'd0);
        check("seq_light", 32'(light), (i < 3) ? 32'(prev_rgb) : 32'(model_rgb(exp_c)));
        check("seq_valid", 32'(light_valid), (c == 0 && i < 3) ? 32'd0 : 32'd1);
      end
    end
    tick();
    check("wrap_colour", 32'(colour), 32'd1);
    check("wrap_light", 32'(light), 32'(model_rgb(3'd6)));

    // Pause for 5 edges mid-HOLD; dwell resumes where it stopped.
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i < 12) begin
        check("pause_colour", 32'(colour), 32'd1);
        check("pause_light", 32'(light), (i < 3) ? 32'(model_rgb(3'd6)) : 32'(model_rgb(3'd1)));
        check("pause_busy", 32'(busy), (i < 3) ? 32'd1 : 32'd0);
      end else begin
        check("resume_colour", 32'(colour), 32'd2);
        check("resume_busy", 32'(busy), 32'd1);
        check("resume_light", 32'(light), 32'(model_rgb(3'd1)));
      end
      if (i == 4) run = 1'b0;
      if (i == 9) run = 1'b1;
    end

    // White override pulse of 3 cycles around colour 4.
    for (int t = 1; t <= 21; t++) begin
      tick();
      if (t >= 14) begin
        if (t == 14 || t == 15)      exp_light = model_rgb(3'd3);
        else if (t >= 16 && t <= 18) exp_light = 24'hFFFFFF;
        else                         exp_light = model_rgb(3'd4);
        check("white_light", 32'(light), 32'(exp_light));
        check("white_colour", 32'(colour), (t < 21) ? 32'd4 : 32'd5);
      end
      if (t == 15) white_req = 1'b1;
      if (t == 18) white_req = 1'b0;
    end

    // Reset one cycle after a colour change (mid-lookup).
    rst = 1'b1; run = 1'b0;
    tick();
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_light", 32'(light), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(light_valid), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_colour", 32'(colour), 32'd0);

`ifdef LIGHT_SEQ_STEP_EN
    // Step ignored in LOOKUP, forces advance in HOLD.
    run = 1'b1;
    tick();
    check("step_start", 32'(colour), 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_lookup_colour", 32'(colour), 32'd1);
    check("step_lookup_busy", 32'(busy), 32'd1);
    tick(); tick();
    check("step_hold_light", 32'(light), 32'(model_rgb(3'd1)));
    check("step_hold_busy", 32'(busy), 32'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_adv_colour", 32'(colour), 32'd2);
    check("step_adv_busy", 32'(busy), 32'd1);
    tick(); tick(); tick();
    check("step_next_light", 32'(light), 32'(model_rgb(3'd2)));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
